tri_bus_ctrl: RTL and testbench



---
 rtl/tri_bus_if.sv | 26 ++
 rtl/tri_bus_ctrl.sv | 128 ++++++++++++
 tb/tb_tri_bus_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tri_bus_if.sv
// Handshake and bus signals between the tri-state bus controller and its sources.
// The master modport is the controller side; the slave modport is the requesters/bus side.
interface tri_bus_if #(
  parameter int DATA_W = 1
);
  logic [3:0]        req;
  logic [3:0]        done;
  logic [DATA_W-1:0] bus_in;
  logic              s0;
  logic              s1;
  logic              e;
  logic [3:0]        gnt;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [1:0]        rx_src;

  modport master (
    input  req, done, bus_in,
    output s0, s1, e, gnt, rx_data, rx_valid, rx_src
  );

  modport slave (
    output req, done, bus_in,
    input  s0, s1, e, gnt, rx_data, rx_valid, rx_src
  );
endinterface

// File: rtl/tri_bus_ctrl.sv
// Round-robin owner select for a 4-source tri-state bus, with bounded hold,
// a turnaround cycle between owners, and capture of the resolved bus value.
//
// state | meaning
// IDLE  | no owner; arbitrate on the next edge when any request is present
// GRANT | one source drives the bus; capture every edge until an exit condition
// TURN  | single dead cycle, all drivers off, before re-arbitration
module tri_bus_ctrl #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  tri_bus_if.master bus
);

  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              e_q, e_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [1:0]        rx_src_q, rx_src_d;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;
  logic       owner_exit;

  // First requesting source starting at ptr and wrapping modulo 4.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign owner_exit = bus.done[sel_q] || !bus.req[sel_q] || (hcnt_q == HCNT_LAST);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    e_d        = e_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    hcnt_d     = hcnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_src_d   = rx_src_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          e_d     = 1'b1;
          gnt_d   = 4'b0001 << win;
          hcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rx_data_d  = bus.bus_in;
        rx_src_d   = sel_q;
        rx_valid_d = 1'b1;
        hcnt_d     = hcnt_q + HW'(1);
        if (owner_exit) begin
          e_d     = 1'b0;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          state_d = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        e_d     = 1'b0;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      e_q        <= 1'b0;
      gnt_q      <= 4'b0000;
      ptr_q      <= 2'd0;
      hcnt_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_src_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      e_q        <= e_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      hcnt_q     <= hcnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_src_q   <= rx_src_d;
    end
  end

  assign bus.s0       = sel_q[0];
  assign bus.s1       = sel_q[1];
  assign bus.e        = e_q;
  assign bus.gnt      = gnt_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_src   = rx_src_q;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed stimulus for tri_bus_ctrl; expected owners and captures are queued
// by the stimulus and consumed by a negedge monitor.
module tb_tri_bus_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tri_bus_if #(.DATA_W(1)) bif ();

  tri_bus_ctrl #(.DATA_W(1), .HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] src;
    logic       data;
  } rx_t;

  rx_t        exp_rx[$];
  logic [1:0] exp_own[$];
  int         checks   = 0;
  int         failures = 0;
  logic       e_prev   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [1:0] src, input logic data, input int n);
    rx_t r;
    r.src  = src;
    r.data = data;
    for (int k = 0; k < n; k++) exp_rx.push_back(r);
  endtask

  // Monitor: new owners on e rising, captures on rx_valid, gnt/e consistency every cycle.
  always @(negedge clk) begin
    rx_t        r;
    logic [1:0] o;
    logic [3:0] gexp;
    gexp = bif.e ? (4'b0001 << {bif.s1, bif.s0}) : 4'b0000;
    check("gnt_vs_sel", {28'd0, bif.gnt}, {28'd0, gexp});
    if (bif.e && !e_prev) begin
      if (exp_own.size() == 0) begin
        check("unexpected_grant", 32'd1, 32'd0);
      end else begin
        o = exp_own.pop_front();
        check("owner", {30'd0, bif.s1, bif.s0}, {30'd0, o});
      end
    end
    if (bif.rx_valid) begin
      check("rx_valid_needs_e", {31'd0, e_prev}, 32'd1);
      if (exp_rx.size() == 0) begin
        check("unexpected_rx", 32'd1, 32'd0);
      end else begin
        r = exp_rx.pop_front();
        check("rx_src", {30'd0, bif.rx_src}, {30'd0, r.src});
        check("rx_data", {31'd0, bif.rx_data}, {31'd0, r.data});
      end
    end
    e_prev = bif.e;
  end

  logic [1:0] rr_order[5];

  initial begin
    bif.req    = 4'b1111;
    bif.done   = 4'b0000;
    bif.bus_in = 1'b0;
    rst        = 1'b1;

    // Reset held with all requests pending.
    tick(2);
    check("rst_e", {31'd0, bif.e}, 32'd0);
    check("rst_s", {30'd0, bif.s1, bif.s0}, 32'd0);
    check("rst_gnt", {28'd0, bif.gnt}, 32'd0);
    check("rst_rx_valid", {31'd0, bif.rx_valid}, 32'd0);
    check("rst_rx_data", {31'd0, bif.rx_data}, 32'd0);
    check("rst_rx_src", {30'd0, bif.rx_src}, 32'd0);
    exp_own.push_back(2'd0);
    push_rx(2'd0, 1'b0, 1);
    rst = 1'b0;
    tick(1);
    check("first_e", {31'd0, bif.e}, 32'd1);
    check("first_gnt", {28'd0, bif.gnt}, 32'h1);
    bif.req = 4'b0000;
    tick(4);

    // Single source 2, done on its 3rd grant cycle (ptr is 1 here).
    bif.bus_in = 1'b1;
    bif.req    = 4'b0100;
    exp_own.push_back(2'd2);
    push_rx(2'd2, 1'b1, 3);
    tick(1);
    check("single_gnt_c1", {28'd0, bif.gnt}, 32'h4);
    tick(1);
    check("single_gnt_c2", {28'd0, bif.gnt}, 32'h4);
    tick(1);
    check("single_gnt_c3", {28'd0, bif.gnt}, 32'h4);
    bif.done = 4'b0100;
    tick(1);
    bif.done = 4'b0000;
    bif.req  = 4'b0000;
    check("single_turn_e", {31'd0, bif.e}, 32'd0);
    tick(2);

    // Round robin from ptr=3 with full hold and 2-cycle gaps.
    rr_order = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    bif.bus_in = 1'b0;
    bif.req    = 4'b1111;
    foreach (rr_order[k]) begin
      exp_own.push_back(rr_order[k]);
      push_rx(rr_order[k], 1'b0, 4);
    end
    tick(1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        check("rr_e_hold", {31'd0, bif.e}, 32'd1);
        check("rr_gnt", {28'd0, bif.gnt}, {28'd0, 4'b0001 << rr_order[k]});
        tick(1);
      end
      check("rr_gap1", {31'd0, bif.e}, 32'd0);
      if (k == 4) bif.req = 4'b0000;
      tick(1);
      check("rr_gap2", {31'd0, bif.e}, 32'd0);
      tick(1);
    end
    tick(2);

    // Owner 1 drops its request after 2 cycles while source 3 waits.
    bif.bus_in = 1'b1;
    bif.req    = 4'b1010;
    exp_own.push_back(2'd1);
    push_rx(2'd1, 1'b1, 2);
    exp_own.push_back(2'd3);
    push_rx(2'd3, 1'b1, 1);
    tick(2);
    bif.req = 4'b1000;
    tick(1);
    check("drop_turn_e", {31'd0, bif.e}, 32'd0);
    tick(1);
    check("drop_idle_e", {31'd0, bif.e}, 32'd0);
    tick(1);
    check("drop_next_gnt", {28'd0, bif.gnt}, 32'h8);
    bif.req = 4'b0000;
    tick(4);

    // done[0] coincides with hold expiry; stray done[2] from a non-owner.
    bif.bus_in = 1'b0;
    bif.req    = 4'b0101;
    exp_own.push_back(2'd0);
    push_rx(2'd0, 1'b0, 4);
    tick(2);
    bif.done = 4'b0100;
    tick(1);
    bif.done = 4'b0000;
    check("stray_done_e", {31'd0, bif.e}, 32'd1);
    check("stray_done_gnt", {28'd0, bif.gnt}, 32'h1);
    tick(1);
    bif.done = 4'b0001;
    tick(1);
    bif.done = 4'b0000;
    check("simul_exit_e", {31'd0, bif.e}, 32'd0);
    bif.req = 4'b1110;
    exp_own.push_back(2'd1);
    push_rx(2'd1, 1'b0, 1);
    tick(2);
    check("simul_ptr_gnt", {28'd0, bif.gnt}, 32'h2);
    bif.req = 4'b0000;
    tick(4);

    // Reset on source 3's 2nd grant cycle.
    bif.bus_in = 1'b1;
    bif.req    = 4'b1000;
    exp_own.push_back(2'd3);
    push_rx(2'd3, 1'b1, 1);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("midrst_e", {31'd0, bif.e}, 32'd0);
    check("midrst_gnt", {28'd0, bif.gnt}, 32'h0);
    check("midrst_rx_valid", {31'd0, bif.rx_valid}, 32'd0);
    rst     = 1'b0;
    bif.req = 4'b1001;
    exp_own.push_back(2'd0);
    push_rx(2'd0, 1'b1, 1);
    tick(1);
    check("midrst_regrant", {28'd0, bif.gnt}, 32'h1);
    bif.req = 4'b0000;
    tick(4);

    check("pending_owners", exp_own.size(), 32'd0);
    check("pending_rx", exp_rx.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
